safe_lockout_ctrl: RTL and testbench
====================================

// Module: safe_lockout_ctrl
// PURPOSE
//  Sequencer for the safe's countdown timer. Tracks entry sessions, wrong-password
//  attempts and lockouts. Drives the timer's run_timer, reset_timer and timer_mode_5min
//  inputs, and consumes its time_out output. Sits between the keypad/password
//  comparator and the lock actuator / status display.
// PARAMETERS
//  MAX_FAIL   3  consecutive wrong attempts that trigger a lockout (>=1)
//  ESC_LOCKS  2  lockout number at which the 5-min mode is used instead of 1-min (>=1)
//  CNT_W      3  width of fail_cnt / lock_cnt; must hold max(MAX_FAIL, ESC_LOCKS)
// PORTS
//  clk              in   1      system clock
//  rst              in   1      asynchronous reset, active-high
//  key_pressed      in   1      1-cycle pulse: any keypad key accepted
//  pw_valid         in   1      1-cycle pulse: comparator result valid
//  pw_match         in   1      comparator result, qualified by pw_valid
//  close_req        in   1      1-cycle pulse: door closed / user relock
//  time_out         in   1      timer expired (level, held until reset_timer)
//  run_timer        out  1      timer count enable
//  reset_timer      out  1      1-cycle timer reload pulse
//  timer_mode_5min  out  1      reload value select: 0 = 1 min, 1 = 5 min
//  lock_open        out  1      actuator release
//  locked_out       out  1      lockout status (keypad disabled)
//  entry_abort      out  1      1-cycle pulse: entry window expired
//  fail_cnt         out  CNT_W  consecutive wrong attempts
//  lock_cnt         out  CNT_W  lockouts since last successful open (saturating)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; fail_cnt = 0; lock_cnt = 0.
//  - All outputs are registered. A state transition takes effect on the clock edge
//    at which its cause is sampled.
//  - reset_timer is high in exactly the first cycle after entering ENTRY, LOCKOUT or
//    OPEN. timer_mode_5min is valid in that cycle and held for the rest of the state.
//  - time_out is ignored while reset_timer = 1, because the timer's value is stale in
//    that cycle.
//  - IDLE: run_timer = 0.
//    key_pressed -> ENTRY, mode = 0.
//  - ENTRY: run_timer = 1 (1-min entry window). Priority pw_valid > time_out.
//    pw_valid & pw_match -> OPEN, mode = 0; fail_cnt := 0; lock_cnt := 0.
//    pw_valid & !pw_match, with fail_cnt+1 < MAX_FAIL -> IDLE; fail_cnt increments.
//    pw_valid & !pw_match, with fail_cnt+1 = MAX_FAIL -> LOCKOUT; fail_cnt := 0;
//      lock_cnt increments (saturating); mode = (new lock_cnt >= ESC_LOCKS).
//    time_out -> IDLE; entry_abort pulses for 1 cycle; fail_cnt is unchanged.
//  - LOCKOUT: run_timer = 1; locked_out = 1.
//    key_pressed, pw_valid and close_req are ignored.
//    time_out -> IDLE.
//  - OPEN: run_timer = 1 (1-min auto-relock); lock_open = 1.
//    close_req or time_out -> IDLE.
//    key_pressed and pw_valid are ignored.
//  - key_pressed in any state other than IDLE has no effect.
//  - pw_valid outside ENTRY has no effect; fail_cnt is not changed.
//  - lock_cnt saturates at 2^CNT_W-1 and never wraps.
//  - Any rst assertion mid-operation returns the block immediately to the reset
//    state (lock_open = 0).
// TESTING
//  1 Reset, pulse key_pressed, then pw_valid=1/pw_match=1 -> reset_timer pulse with
//    mode 0; state OPEN; lock_open=1 one cycle after pw_valid.
//  2 Three wrong attempts (MAX_FAIL=3) -> fail_cnt goes 1, 2, then 0; locked_out=1;
//    lock_cnt=1; timer_mode_5min=0.
//  3 Second lockout with no successful open in between (ESC_LOCKS=2) ->
//    timer_mode_5min=1 on the reset_timer cycle; a later correct password clears
//    lock_cnt to 0.
//  4 In ENTRY, assert time_out -> entry_abort pulses for 1 cycle; return to IDLE.
//    Same cycle as pw_valid -> password result wins; no abort.
//  5 During LOCKOUT, pulse key_pressed and pw_valid -> no state change; time_out
//    -> IDLE with locked_out=0.
//  6 Hold time_out=1 stale while entering ENTRY -> no abort in the reset_timer cycle.
//    Assert rst while in OPEN -> lock_open=0 asynchronously.

Source files
------------

// File: rtl/safe_lockout_ctrl.sv
// Sequencer for the safe's countdown timer: entry sessions, wrong-password counting,
// lockouts with escalating duration, and the open/auto-relock window.
module safe_lockout_ctrl #(
  parameter int unsigned MAX_FAIL  = 3,
  parameter int unsigned ESC_LOCKS = 2,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_pressed,
  input  logic             pw_valid,
  input  logic             pw_match,
  input  logic             close_req,
  input  logic             time_out,
  output logic             run_timer,
  output logic             reset_timer,
  output logic             timer_mode_5min,
  output logic             lock_open,
  output logic             locked_out,
  output logic             entry_abort,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] lock_cnt
);

  typedef enum logic [1:0] {StIdle, StEntry, StLockout, StOpen} state_e;

  localparam logic [CNT_W:0]   MaxFail  = (CNT_W+1)'(MAX_FAIL);
  localparam logic [CNT_W:0]   EscLocks = (CNT_W+1)'(ESC_LOCKS);
  localparam logic [CNT_W:0]   OneW     = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] OneC     = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W:0]   fail_inc;
  logic [CNT_W-1:0] lock_inc;
  logic             time_out_ok;

  assign fail_inc    = {1'b0, fail_cnt} + OneW;
  assign lock_inc    = (&lock_cnt) ? lock_cnt : lock_cnt + OneC;
  // The timer has not reloaded yet while reset_timer is high, so its expiry flag is stale.
  assign time_out_ok = time_out & ~reset_timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      run_timer       <= 1'b0;
      reset_timer     <= 1'b0;
      timer_mode_5min <= 1'b0;
      lock_open       <= 1'b0;
      locked_out      <= 1'b0;
      entry_abort     <= 1'b0;
      fail_cnt        <= '0;
      lock_cnt        <= '0;
    end else begin
      reset_timer <= 1'b0;
      entry_abort <= 1'b0;
      case (state_q)
        StIdle: begin
          if (key_pressed) begin
            state_q         <= StEntry;
            run_timer       <= 1'b1;
            reset_timer     <= 1'b1;
            timer_mode_5min <= 1'b0;
          end
        end
        StEntry: begin
          if (pw_valid) begin
            if (pw_match) begin
              state_q         <= StOpen;
              reset_timer     <= 1'b1;
              timer_mode_5min <= 1'b0;
              lock_open       <= 1'b1;
              fail_cnt        <= '0;
              lock_cnt        <= '0;
            end else if (fail_inc < MaxFail) begin
              state_q   <= StIdle;
              run_timer <= 1'b0;
              fail_cnt  <= fail_inc[CNT_W-1:0];
            end else begin
              state_q         <= StLockout;
              reset_timer     <= 1'b1;
              timer_mode_5min <= ({1'b0, lock_inc} >= EscLocks);
              locked_out      <= 1'b1;
              fail_cnt        <= '0;
              lock_cnt        <= lock_inc;
            end
          end else if (time_out_ok) begin
            state_q     <= StIdle;
            run_timer   <= 1'b0;
            entry_abort <= 1'b1;
          end
        end
        StLockout: begin
          if (time_out_ok) begin
            state_q    <= StIdle;
            run_timer  <= 1'b0;
            locked_out <= 1'b0;
          end
        end
        StOpen: begin
          if (close_req || time_out_ok) begin
            state_q   <= StIdle;
            run_timer <= 1'b0;
            lock_open <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          run_timer  <= 1'b0;
          lock_open  <= 1'b0;
          locked_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_safe_lockout_ctrl.sv
// Scoreboard bench for safe_lockout_ctrl: a session-level reference model predicts every
// cycle's outputs; a separate monitor compares them as the DUT presents them.
module tb_safe_lockout_ctrl;

  localparam int unsigned MAX_FAIL  = 3;
  localparam int unsigned ESC_LOCKS = 2;
  localparam int unsigned CNT_W     = 3;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             key_pressed = 1'b0;
  logic             pw_valid = 1'b0;
  logic             pw_match = 1'b0;
  logic             close_req = 1'b0;
  logic             time_out = 1'b0;
  logic             run_timer;
  logic             reset_timer;
  logic             timer_mode_5min;
  logic             lock_open;
  logic             locked_out;
  logic             entry_abort;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] lock_cnt;

  safe_lockout_ctrl #(
    .MAX_FAIL (MAX_FAIL),
    .ESC_LOCKS(ESC_LOCKS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_pressed    (key_pressed),
    .pw_valid       (pw_valid),
    .pw_match       (pw_match),
    .close_req      (close_req),
    .time_out       (time_out),
    .run_timer      (run_timer),
    .reset_timer    (reset_timer),
    .timer_mode_5min(timer_mode_5min),
    .lock_open      (lock_open),
    .locked_out     (locked_out),
    .entry_abort    (entry_abort),
    .fail_cnt       (fail_cnt),
    .lock_cnt       (lock_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             run;
    logic             reload;
    logic             mode_care;
    logic             mode;
    logic             open;
    logic             lockout;
    logic             abort;
    logic [CNT_W-1:0] fail;
    logic [CNT_W-1:0] lock;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   started = 0;

  // Reference model: which phase the safe is in plus the counters the user sees.
  typedef enum int {MIdle, MEntry, MLockout, MOpen} phase_e;
  phase_e m_phase;
  int     m_fail;
  int     m_lock;
  bit     m_reload;
  bit     m_mode;
  bit     m_care;
  bit     m_abort;

  function automatic exp_t snapshot();
    exp_t e;
    e.run       = (m_phase != MIdle);
    e.reload    = m_reload;
    e.mode_care = m_care;
    e.mode      = m_mode;
    e.open      = (m_phase == MOpen);
    e.lockout   = (m_phase == MLockout);
    e.abort     = m_abort;
    e.fail      = CNT_W'(m_fail);
    e.lock      = CNT_W'(m_lock);
    return e;
  endfunction

  task automatic model_reset();
    m_phase  = MIdle;
    m_fail   = 0;
    m_lock   = 0;
    m_reload = 0;
    m_mode   = 0;
    m_care   = 1;
    m_abort  = 0;
  endtask

  task automatic go(input phase_e p, input bit reload);
    m_phase  = p;
    m_reload = reload;
    m_care   = (p != MIdle);
  endtask

  task automatic model_step(input bit kp, input bit pv, input bit pm, input bit cr,
                            input bit to);
    bit expired;
    expired  = to && !m_reload;
    m_reload = 0;
    m_abort  = 0;
    case (m_phase)
      MIdle: if (kp) begin
        go(MEntry, 1);
        m_mode = 0;
      end
      MEntry: begin
        if (pv && pm) begin
          go(MOpen, 1);
          m_mode = 0;
          m_fail = 0;
          m_lock = 0;
        end else if (pv && (m_fail + 1 < int'(MAX_FAIL))) begin
          go(MIdle, 0);
          m_fail++;
        end else if (pv) begin
          go(MLockout, 1);
          m_fail = 0;
          if (m_lock < CNT_MAX) m_lock++;
          m_mode = (m_lock >= int'(ESC_LOCKS));
        end else if (expired) begin
          go(MIdle, 0);
          m_abort = 1;
        end
      end
      MLockout: if (expired) go(MIdle, 0);
      MOpen:    if (cr || expired) go(MIdle, 0);
      default:  go(MIdle, 0);
    endcase
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic cycle(input bit kp, input bit pv, input bit pm, input bit cr, input bit to);
    key_pressed = kp;
    pw_valid    = pv;
    pw_match    = pm;
    close_req   = cr;
    time_out    = to;
    model_step(kp, pv, pm, cr, to);
    exp_q.push_back(snapshot());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset applied between clock edges and held over one rising edge.
  task automatic do_reset();
    key_pressed = 0;
    pw_valid    = 0;
    pw_match    = 0;
    close_req   = 0;
    time_out    = 0;
    model_reset();
    exp_q.push_back(snapshot());
    exp_q.push_back(snapshot());
    started = 1;
    rst     = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wrong_attempt();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
  endtask

  task automatic to_lockout();
    for (int i = 0; i < 8 && m_phase != MLockout; i++) wrong_attempt();
  endtask

  task automatic leave_lockout();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (started) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow @%0t: no expected entry queued", $time);
        end else begin
          e             = exp_q.pop_front();
          act.run       = run_timer;
          act.reload    = reset_timer;
          act.mode_care = e.mode_care;
          act.mode      = e.mode_care ? timer_mode_5min : e.mode;
          act.open      = lock_open;
          act.lockout   = locked_out;
          act.abort     = entry_abort;
          act.fail      = fail_cnt;
          act.lock      = lock_cnt;
          if (act !== e) begin
            errors++;
            $display({"FAIL outputs @%0t actual run=%b rt=%b mode=%b open=%b lo=%b abort=%b ",
                      "fail=%0d lock=%0d required run=%b rt=%b mode=%b open=%b lo=%b ",
                      "abort=%b fail=%0d lock=%0d"},
                     $time, act.run, act.reload, act.mode, act.open, act.lockout, act.abort,
                     act.fail, act.lock, e.run, e.reload, e.mode, e.open, e.lockout,
                     e.abort, e.fail, e.lock);
          end
        end
      end
    end
  end

  initial begin : stimulus
    @(negedge clk);
    do_reset();
    idle(2);

    // Correct password opens, then user relocks.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    idle(3);
    cycle(0, 0, 0, 1, 0);
    idle(1);

    // Two lockouts back to back escalate to 5-min; a correct password clears lock_cnt.
    to_lockout();
    idle(2);
    leave_lockout();
    to_lockout();
    idle(2);
    leave_lockout();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    idle(1);

    // Entry window expiry, then password result beating a same-cycle expiry.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    idle(1);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    idle(1);

    // Keypad, password and close are ignored during a lockout.
    to_lockout();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    leave_lockout();

    // Stale time_out across entry, then async reset while open.
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    idle(2);
    do_reset();
    idle(1);

    // Enough lockouts without an open to saturate lock_cnt.
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      to_lockout();
      leave_lockout();
    end

    // Random traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cycle(bit'($urandom_range(0, 99) < 30), bit'($urandom_range(0, 99) < 25),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 99) < 10),
              bit'($urandom_range(0, 99) < 12));
      end
    end
    idle(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
